// File: rtl/dct_pkg.sv
// dct_engine shared types, Q-format constants and ROM/lifter generators.
// DCT_LIFTER_EN is consumed by dct_engine.sv.
package dct_pkg;

  localparam int  COEF_FRAC = 15;
  localparam int  LIFT_FRAC = 11;
  localparam int  LIFTER_L  = 22;
  localparam real PI        = 3.14159265358979323846;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  function automatic int acc_width(int in_w, int nf);
    return in_w + 16 + $clog2(nf);
  endfunction

  // Orthonormal DCT-II basis in Q1.15, round-to-nearest, saturated
  function automatic logic signed [15:0] dct_coef(int k, int n, int nf);
    real s;
    real v;
    s = (k == 0) ? $sqrt(1.0 / nf) : $sqrt(2.0 / nf);
    v = s * $cos(PI * k * (n + 0.5) / nf) * real'(1 << COEF_FRAC);
    v = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
    if (v > 32767.0) v = 32767.0;
    if (v < -32768.0) v = -32768.0;
    return 16'($rtoi(v));
  endfunction

  function automatic logic [15:0] dct_lifter(int k);
    real w;
    w = 1.0 + (LIFTER_L / 2.0) * $sin(PI * k / LIFTER_L);
    return 16'($rtoi($floor(w * real'(1 << LIFT_FRAC) + 0.5)));
  endfunction

endpackage

// File: rtl/dct_coef_rom.sv
// Cosine coefficient ROM, Q1.15, addressed {j,n} with j the output index.
// One cycle read latency; contents fixed at elaboration.
module dct_coef_rom
  import dct_pkg::*;
#(
  parameter int NUM_FILTERS = 40,
  parameter int NUM_CEPS    = 12,
  parameter int SKIP_C0     = 1,
  localparam int NW = $clog2(NUM_FILTERS),
  localparam int JW = $clog2(NUM_CEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [JW+NW-1:0]   addr,
  output logic signed [15:0] coef
);

  localparam int DEPTH = 1 << (JW + NW);

  logic signed [15:0] rom_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam int JI = i >> NW;
    localparam int NI = i % (1 << NW);
    if (JI < NUM_CEPS && NI < NUM_FILTERS) begin : g_used
      assign rom_w[i] = dct_coef(JI + SKIP_C0, NI, NUM_FILTERS);
    end else begin : g_pad
      assign rom_w[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coef <= '0;
    else        coef <= rom_w[addr];
  end

endmodule

// File: rtl/dct_engine.sv
// DCT-II engine: log-mel buffer, 1 MAC/cycle sweep, streamed cepstra.
// Define DCT_LIFTER_EN to add sinusoidal liftering (+1 cycle latency).
module dct_engine
  import dct_pkg::*;
#(
  parameter int NUM_FILTERS = 40,
  parameter int NUM_CEPS    = 12,
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 32,
  parameter int SKIP_C0     = 1,
  localparam int NW = $clog2(NUM_FILTERS),
  localparam int JW = $clog2(NUM_CEPS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  input  logic [NW-1:0]               in_ptr_i,
  input  logic signed [IN_WIDTH-1:0]  in_data_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        out_valid_o,
  output logic [JW-1:0]               out_ptr_o,
  output logic signed [OUT_WIDTH-1:0] out_data_o,
  output logic                        done_o,
  output logic                        overrun_o
);

  localparam int PW = IN_WIDTH + 16;
  localparam int AW = acc_width(IN_WIDTH, NUM_FILTERS);
  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (COEF_FRAC - 1);

  state_e state_q, state_d;
  logic [JW-1:0] j_q;
  logic [NW-1:0] n_q;
  logic run, accept, last_n, last_pair, emit_last;

  logic signed [IN_WIDTH-1:0] buffer [NUM_FILTERS];

  assign run       = state_q == RUN;
  assign accept    = state_q == IDLE && start_i;
  assign busy_o    = state_q != IDLE;
  assign last_n    = int'(n_q) == NUM_FILTERS - 1;
  assign last_pair = last_n && int'(j_q) == NUM_CEPS - 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)   state_d = RUN;
      RUN:     if (last_pair) state_d = DRAIN;
      DRAIN:   if (emit_last) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q <= '0;
      n_q <= '0;
    end else if (accept) begin
      j_q <= '0;
      n_q <= '0;
    end else if (run) begin
      if (last_n) begin
        n_q <= '0;
        j_q <= j_q + 1'b1;
      end else begin
        n_q <= n_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid_i && !busy_o && int'(in_ptr_i) < NUM_FILTERS)
      buffer[in_ptr_i] <= in_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       overrun_o <= 1'b0;
    else if (accept)                  overrun_o <= 1'b0;
    else if (in_valid_i && busy_o)    overrun_o <= 1'b1;
  end

  // Stage 1: ROM and buffer reads
  logic signed [15:0]         s1_coef;
  logic signed [IN_WIDTH-1:0] s1_x;
  logic                       s1_valid, s1_first, s1_kend, s1_final;
  logic [JW-1:0]              s1_j;

  dct_coef_rom #(
    .NUM_FILTERS (NUM_FILTERS),
    .NUM_CEPS    (NUM_CEPS),
    .SKIP_C0     (SKIP_C0)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  ({j_q, n_q}),
    .coef  (s1_coef)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_kend  <= 1'b0;
      s1_final <= 1'b0;
      s1_j     <= '0;
      s1_x     <= '0;
    end else begin
      s1_valid <= run;
      s1_first <= n_q == '0;
      s1_kend  <= last_n;
      s1_final <= last_pair;
      s1_j     <= j_q;
      s1_x     <= buffer[n_q];
    end
  end

  // Stage 2: multiply-accumulate
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_q;
  logic                 s2_valid, s2_final;
  logic [JW-1:0]        s2_j;

  assign prod = s1_x * s1_coef;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      s2_valid <= 1'b0;
      s2_final <= 1'b0;
      s2_j     <= '0;
    end else begin
      if (s1_valid)
        acc_q <= (s1_first ? '0 : acc_q) + {{(AW-PW){prod[PW-1]}}, prod};
      s2_valid <= s1_valid && s1_kend;
      s2_final <= s1_valid && s1_final;
      s2_j     <= s1_j;
    end
  end

  // Stage 3: round, saturate, register
  logic signed [AW-1:0]        shf;
  logic signed [OUT_WIDTH-1:0] raw;
  logic signed [OUT_WIDTH-1:0] r3_data;
  logic [JW-1:0]               r3_ptr;
  logic                        r3_valid, r3_done;

  assign shf = (acc_q + HALF) >>> COEF_FRAC;

  always_comb begin
    raw = shf[OUT_WIDTH-1:0];
    if (!(&shf[AW-1:OUT_WIDTH-1]) && |shf[AW-1:OUT_WIDTH-1])
      raw = {shf[AW-1], {(OUT_WIDTH-1){~shf[AW-1]}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid <= 1'b0;
      r3_done  <= 1'b0;
      r3_ptr   <= '0;
      r3_data  <= '0;
    end else begin
      r3_valid <= s2_valid;
      r3_done  <= s2_final;
      if (s2_valid) begin
        r3_ptr  <= s2_j;
        r3_data <= raw;
      end
    end
  end

`ifdef DCT_LIFTER_EN
  localparam int LW = OUT_WIDTH + 17;
  localparam logic signed [LW-1:0] HALF_L = LW'(1) <<< (LIFT_FRAC - 1);

  logic [15:0]                 lift_w [NUM_CEPS];
  logic signed [LW-1:0]        lp, ls;
  logic signed [OUT_WIDTH-1:0] lifted;
  logic signed [OUT_WIDTH-1:0] r4_data;
  logic [JW-1:0]               r4_ptr;
  logic                        r4_valid, r4_done;

  for (genvar g = 0; g < NUM_CEPS; g++) begin : g_lift
    assign lift_w[g] = dct_lifter(g + SKIP_C0);
  end

  assign lp = r3_data * $signed({1'b0, lift_w[r3_ptr]});
  assign ls = (lp + HALF_L) >>> LIFT_FRAC;

  always_comb begin
    lifted = ls[OUT_WIDTH-1:0];
    if (!(&ls[LW-1:OUT_WIDTH-1]) && |ls[LW-1:OUT_WIDTH-1])
      lifted = {ls[LW-1], {(OUT_WIDTH-1){~ls[LW-1]}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r4_valid <= 1'b0;
      r4_done  <= 1'b0;
      r4_ptr   <= '0;
      r4_data  <= '0;
    end else begin
      r4_valid <= r3_valid;
      r4_done  <= r3_done;
      if (r3_valid) begin
        r4_ptr  <= r3_ptr;
        r4_data <= lifted;
      end
    end
  end

  assign emit_last   = r3_done;
  assign out_valid_o = r4_valid;
  assign out_ptr_o   = r4_ptr;
  assign out_data_o  = r4_data;
  assign done_o      = r4_done;
`else
  assign emit_last   = s2_final;
  assign out_valid_o = r3_valid;
  assign out_ptr_o   = r3_ptr;
  assign out_data_o  = r3_data;
  assign done_o      = r3_done;
`endif

endmodule

// File: tb/tb_dct_engine.sv
// dct_engine bench: random log-mel frames against a real-valued DCT-II model.
// Covers timing, overrun, mid-run start, out-of-range writes and reset.
module tb_dct_engine;

  localparam int N  = 40;
  localparam int NC = 12;
  localparam int K0 = 1;
`ifdef DCT_LIFTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int  LAST = NC * N + LAT;
  localparam real PI   = 3.14159265358979323846;

  logic               clk = 0;
  logic               rst_n = 0;
  logic               in_valid = 0;
  logic [5:0]         in_ptr = '0;
  logic signed [31:0] in_data = '0;
  logic               start = 0;
  logic               busy, out_valid, done, overrun;
  logic [3:0]         out_ptr;
  logic signed [31:0] out_data;

  int nchk = 0;
  int nfail = 0;
  int x [N];

  dct_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ptr_i    (in_ptr),
    .in_data_i   (in_data),
    .start_i     (start),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_ptr_o   (out_ptr),
    .out_data_o  (out_data),
    .done_o      (done),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp, input longint tol = 0);
    nchk++;
    if (got - exp > tol || exp - got > tol) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  // Ideal orthonormal DCT-II of x, in Q16.16 LSBs
  function automatic longint model(int j);
    int  k = j + K0;
    real s, y;
    s = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
    y = 0.0;
    for (int n = 0; n < N; n++)
      y += real'(x[n]) * $cos(PI * k * (n + 0.5) / N);
    y *= s;
`ifdef DCT_LIFTER_EN
    y *= 1.0 + 11.0 * $sin(PI * k / 22.0);
`endif
    return longint'(y);
  endfunction

  // Bound from Q1.15 coefficient quantisation plus output rounding
  function automatic longint tol_of();
    real sa = 0.0;
    for (int n = 0; n < N; n++)
      sa += (x[n] < 0) ? -real'(x[n]) : real'(x[n]);
`ifdef DCT_LIFTER_EN
    return longint'(sa * 0.5 / 32768.0 * 12.1 + sa / 65536.0 * 0.01) + 4;
`else
    return longint'(sa * 0.5 / 32768.0) + 2;
`endif
  endfunction

  task automatic fill_random();
    for (int n = 0; n < N; n++)
      x[n] = int'($urandom_range(524288, 0)) - 262144;
  endtask

  task automatic run_frame(input bit disturb, input int rst_at);
    int     cyc, got, done_cyc, stray;
    longint tol;
    tol = tol_of();
    for (int n = 0; n < N - 1; n++) begin
      @(negedge clk);
      in_valid = 1;
      in_ptr   = 6'(n);
      in_data  = x[n];
    end
    @(negedge clk);
    in_ptr  = 6'd63;
    in_data = 32'h7fff_ffff;
    @(negedge clk);
    in_ptr  = 6'(N - 1);
    in_data = x[N-1];
    start   = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    start    = 0;
    cyc = 0; got = 0; done_cyc = -1; stray = 0;
    repeat (LAST + 6) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) begin
        chk("busy_rise", busy, 1);
        chk("overrun_clr", overrun, 0);
      end
      if (disturb && cyc == 100) begin
        in_valid = 1;
        in_ptr   = 6'd5;
        in_data  = $urandom;
      end
      if (disturb && cyc == 101) in_valid = 0;
      if (disturb && cyc == 150) start = 1;
      if (disturb && cyc == 151) start = 0;
      if (rst_at > 0 && cyc == rst_at) begin
        rst_n = 0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
      end
      if (rst_at > 0 && cyc > rst_at) begin
        stray += int'(out_valid) + int'(done);
      end else begin
        if (out_valid) begin
          chk("ptr", out_ptr, got);
          chk("valid_cyc", cyc, (got + 1) * N + LAT);
          chk("data", out_data, model(got), tol);
          got++;
        end
        if (done) begin
          done_cyc = cyc;
          chk("busy_fall", busy, 0);
        end
        if (cyc == LAST - 1) chk("busy_hold", busy, 1);
      end
    end
    if (rst_at > 0) begin
      chk("stray_after_rst", stray, 0);
      @(negedge clk);
      rst_n = 1;
    end else begin
      chk("count", got, NC);
      chk("done_cyc", done_cyc, LAST);
      chk("overrun", overrun, disturb);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ptr", out_ptr, 0);
    @(negedge clk);
    rst_n = 1;

    for (int n = 0; n < N; n++) x[n] = 0;
    run_frame(0, 0);

    x[0] = 32'h0001_0000;
    run_frame(0, 0);
`ifndef DCT_LIFTER_EN
    chk("impulse_k1", model(0), 14643, 64);
`endif

    for (int n = 0; n < N; n++) x[n] = 32'h0001_0000;
    run_frame(0, 0);

    repeat (3) begin
      fill_random();
      run_frame(0, 0);
    end

    fill_random();
    run_frame(1, 0);
    chk("overrun_sticky", overrun, 1);
    fill_random();
    run_frame(0, 0);

    fill_random();
    run_frame(0, 200);
    fill_random();
    run_frame(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
